mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_arb_select.sv | 27 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: port indices, FSM encoding
// and the counter width used by the latency and starvation counters.
package mem_port_arbiter_pkg;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_DEBUG = 2;
    localparam int NUM_PORTS  = 3;

    // wide enough for MEM_LATENCY-1 and STARVE_LIMIT (both at most 15)
    localparam int CNT_W = 4;

    // the fetch port is read-only, so its write enable never reaches memory
    localparam logic [NUM_PORTS-1:0] WE_MASK = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [1:0] onehot_to_id(input logic [NUM_PORTS-1:0] oh);
        logic [1:0] id;
        id = 2'(PORT_FETCH);
        if (oh[PORT_DATA])       id = 2'(PORT_DATA);
        else if (oh[PORT_DEBUG]) id = 2'(PORT_DEBUG);
        return id;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Fixed-priority selector (data > fetch > debug), overridden in favour of the
// debug port once it has lost STARVE_LIMIT arbitrations in a row.
module arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [CNT_W-1:0]     starve_cnt,
    output logic [NUM_PORTS-1:0] winner
);

    always_comb begin
        winner = '0;
        if (req[PORT_DEBUG] && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            winner[PORT_DEBUG] = 1'b1;
        end else if (req[PORT_DATA]) begin
            winner[PORT_DATA] = 1'b1;
        end else if (req[PORT_FETCH]) begin
            winner[PORT_FETCH] = 1'b1;
        end else if (req[PORT_DEBUG]) begin
            winner[PORT_DEBUG] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port memory arbiter: one access at a time, fixed latency, with a
// starvation guard for the debug port.
//   state     | meaning
//   ST_IDLE   | arbitrate, pulse gnt, latch operands of the winner
//   ST_ACCESS | drive memory for MEM_LATENCY cycles
//   ST_RESP   | pulse done for the latched port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  we,
    input  logic [ADDR_WIDTH-1:0] addr_f,
    input  logic [ADDR_WIDTH-1:0] addr_d,
    input  logic [ADDR_WIDTH-1:0] addr_g,
    input  logic [DATA_WIDTH-1:0] wdata_d,
    input  logic [DATA_WIDTH-1:0] wdata_g,
    output logic [NUM_PORTS-1:0]  gnt,
    output logic [NUM_PORTS-1:0]  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      starve_cnt;
    logic [1:0]            id_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_PORTS-1:0]  winner;

    arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb_select (
        .req        (req),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (|req) state_nxt = ST_ACCESS;
            ST_ACCESS: if (wait_cnt == '0) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // outputs are forced low while reset is high so an aborted access never shows done
    always_comb begin
        gnt       = '0;
        done      = '0;
        busy      = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            busy = (state != ST_IDLE);
            unique case (state)
                ST_IDLE: gnt = winner;
                ST_ACCESS: begin
                    mem_cs    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
                ST_RESP: done = 3'b001 << id_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            id_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;

            if (!req[PORT_DEBUG]) begin
                starve_cnt <= '0;
            end else if ((state == ST_IDLE) && (|req)) begin
                if (winner[PORT_DEBUG])                        starve_cnt <= '0;
                else if (starve_cnt != CNT_W'(STARVE_LIMIT))   starve_cnt <= starve_cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        id_q     <= onehot_to_id(winner);
                        we_q     <= |(we & winner & WE_MASK);
                        wait_cnt <= CNT_W'(MEM_LATENCY - 1);
                        if (winner[PORT_DATA]) begin
                            addr_q  <= addr_d;
                            wdata_q <= wdata_d;
                        end else if (winner[PORT_DEBUG]) begin
                            addr_q  <= addr_g;
                            wdata_q <= wdata_g;
                        end else begin
                            addr_q  <= addr_f;
                            wdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else if (!we_q)     rdata    <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
